// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field positions, opcode flag bits and
// register-select sizing used by the decode/issue stage and its scoreboard.
package cpu_pkg;

  localparam int NREG = 32;
  localparam int SELW = 5;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 21;
  localparam int RS1_MSB = 20;
  localparam int RS1_LSB = 16;
  localparam int RS2_MSB = 15;
  localparam int RS2_LSB = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  // Opcode bit indices: bit 5 set means no register write, bit 4 set means B is imm16.
  localparam int OPF_NOWRITE = 5;
  localparam int OPF_IMM     = 4;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/scoreboard32.sv
// Pending-write scoreboard: one bit per architectural register, set on issue
// of a writer and cleared by writeback.
module scoreboard32
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            set_en,
  input  logic [SELW-1:0] set_sel,
  input  logic            clr_en,
  input  logic [SELW-1:0] clr_sel,
  input  logic [SELW-1:0] rs1_sel,
  input  logic [SELW-1:0] rs2_sel,
  input  logic [SELW-1:0] rd_sel,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rd_busy
);

  logic [NREG-1:0] pending;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_sel] = 1'b1;
    if (clr_en) clr_mask[clr_sel] = 1'b1;
  end

  // Clear is applied first so a same-edge set of the same bit wins.
  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~clr_mask) | set_mask;
  end

  assign rs1_busy = pending[rs1_sel];
  assign rs2_busy = pending[rs2_sel];
  assign rd_busy  = pending[rd_sel];

endmodule

// File: rtl/decode_issue32.sv
// Decode/issue stage: holds one instruction, drives register file selects,
// stalls on RAW/WAW hazards and launches operands into a one-entry EX register.
module decode_issue32
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  output logic [SELW-1:0] asel,
  output logic [SELW-1:0] bsel,
  input  logic [31:0]     rf_a,
  input  logic [31:0]     rf_b,
  input  logic            wb_wen,
  input  logic [SELW-1:0] wb_wsel,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [5:0]      ex_opcode,
  output logic            ex_wen,
  output logic [SELW-1:0] ex_wsel,
  output logic [31:0]     ex_a,
  output logic [31:0]     ex_b
);

  logic            d_valid;
  logic [31:0]     d_instr;
  logic [5:0]      d_op;
  logic [SELW-1:0] d_rd;
  logic [SELW-1:0] d_rs1;
  logic [SELW-1:0] d_rs2;
  logic [15:0]     d_imm;
  logic            d_writes;
  logic            d_uses_imm;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            rd_busy;
  logic            hazard;
  logic            issue;
  logic            accept;
  logic [31:0]     b_operand;

  assign d_op       = d_instr[OP_MSB:OP_LSB];
  assign d_rd       = d_instr[RD_MSB:RD_LSB];
  assign d_rs1      = d_instr[RS1_MSB:RS1_LSB];
  assign d_rs2      = d_instr[RS2_MSB:RS2_LSB];
  assign d_imm      = d_instr[IMM_MSB:IMM_LSB];
  assign d_writes   = ~d_op[OPF_NOWRITE];
  assign d_uses_imm = d_op[OPF_IMM];

  // The held instruction's sources feed the register file even for imm ops.
  assign asel = d_rs1;
  assign bsel = d_rs2;

  scoreboard32 u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   (issue & d_writes),
    .set_sel  (d_rd),
    .clr_en   (wb_wen),
    .clr_sel  (wb_wsel),
    .rs1_sel  (d_rs1),
    .rs2_sel  (d_rs2),
    .rd_sel   (d_rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy)
  );

  // Hazards use the registered scoreboard, so writeback never bypasses in the same cycle.
  assign hazard    = rs1_busy | (~d_uses_imm & rs2_busy) | (d_writes & rd_busy);
  assign issue     = d_valid & ~hazard & (~ex_valid | ex_ready);
  assign if_ready  = ~d_valid | issue;
  assign accept    = if_valid & if_ready;
  assign b_operand = d_uses_imm ? sext16(d_imm) : rf_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      d_valid <= 1'b0;
      d_instr <= '0;
    end else if (accept) begin
      d_valid <= 1'b1;
      d_instr <= if_instr;
    end else if (issue) begin
      d_valid <= 1'b0;
    end
  end

  // EX data only changes on issue, so it stays stable under backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid  <= 1'b0;
      ex_opcode <= '0;
      ex_wen    <= 1'b0;
      ex_wsel   <= '0;
      ex_a      <= '0;
      ex_b      <= '0;
    end else if (issue) begin
      ex_valid  <= 1'b1;
      ex_opcode <= d_op;
      ex_wen    <= d_writes;
      ex_wsel   <= d_rd;
      ex_a      <= rf_a;
      ex_b      <= b_operand;
    end else if (ex_ready) begin
      ex_valid  <= 1'b0;
    end
  end

endmodule
